// File: rtl/uart_reg_bridge.sv
`timescale 1ns/1ps
// Byte-protocol bridge: 'W' addr data -> register write + ACK, 'R' addr -> register read + data.
// Define UART_REG_BRIDGE_TIMEOUT_EN to abandon partial packets after TIMEOUT_CYCLES of silence.
module uart_reg_bridge #(
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 32000,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B,
    parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
    input  logic       clk32_i,
    input  logic       reset_i,
    input  logic [7:0] rxdata_i,
    input  logic       rx_enable_i,
    output logic [7:0] txdata_o,
    output logic       tx_enable_o,
    input  logic       tx_ready_i,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    output logic       reg_re_o,
    input  logic [7:0] reg_rdata_i,
    output logic       rx_drop_o
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StData, StWrite, StRead, StRdWait, StSend, StSendWait
    } state_e;

    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [1:0] RdLat    = 2'(READ_LATENCY);

    state_e     state_q;
    logic       is_write_q;
    logic [1:0] rd_cnt_q;
    logic [7:0] txdata_q;
    logic       tx_enable_q;
    logic [7:0] reg_addr_q;
    logic [7:0] reg_wdata_q;
    logic       reg_we_q;
    logic       reg_re_q;
    logic       rx_drop_q;
    logic       busy;

    assign busy = state_q inside {StWrite, StRead, StRdWait, StSend, StSendWait};

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk32_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            is_write_q  <= 1'b0;
            rd_cnt_q    <= 2'd0;
            txdata_q    <= 8'h00;
            tx_enable_q <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            rx_drop_q   <= 1'b0;
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
            tmo_q       <= 16'd0;
`endif
        end else begin
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            tx_enable_q <= 1'b0;
            rx_drop_q   <= rx_enable_i && busy;
            // Entering StSend pre-issues tx_enable when the transmitter is already idle.
            unique case (state_q)
                StIdle: begin
                    if (rx_enable_i) begin
                        if (rxdata_i == CmdWrite || rxdata_i == CmdRead) begin
                            is_write_q <= (rxdata_i == CmdWrite);
                            state_q    <= StAddr;
                        end else begin
                            txdata_q    <= NAK_BYTE;
                            tx_enable_q <= tx_ready_i;
                            state_q     <= StSend;
                        end
                    end
                end
                StAddr: begin
                    if (rx_enable_i) begin
                        reg_addr_q <= rxdata_i;
                        if (is_write_q) begin
                            state_q <= StData;
                        end else begin
                            reg_re_q <= 1'b1;
                            state_q  <= StRead;
                        end
                    end
                end
                StData: begin
                    if (rx_enable_i) begin
                        reg_wdata_q <= rxdata_i;
                        reg_we_q    <= 1'b1;
                        state_q     <= StWrite;
                    end
                end
                StWrite: begin
                    txdata_q    <= ACK_BYTE;
                    tx_enable_q <= tx_ready_i;
                    state_q     <= StSend;
                end
                StRead: begin
                    if (READ_LATENCY == 0) begin
                        txdata_q    <= reg_rdata_i;
                        tx_enable_q <= tx_ready_i;
                        state_q     <= StSend;
                    end else begin
                        rd_cnt_q <= 2'd1;
                        state_q  <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (rd_cnt_q == RdLat) begin
                        txdata_q    <= reg_rdata_i;
                        tx_enable_q <= tx_ready_i;
                        state_q     <= StSend;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 2'd1;
                    end
                end
                StSend: begin
                    if (tx_enable_q) begin
                        state_q <= StSendWait;
                    end else begin
                        tx_enable_q <= tx_ready_i;
                    end
                end
                StSendWait: begin
                    if (!tx_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
            if ((state_q == StAddr || state_q == StData) && !rx_enable_i) begin
                if (tmo_q == TmoLast) begin
                    tmo_q   <= 16'd0;
                    state_q <= StIdle;
                end else begin
                    tmo_q <= tmo_q + 16'd1;
                end
            end else begin
                tmo_q <= 16'd0;
            end
`endif
        end
    end

    assign txdata_o    = txdata_q;
    assign tx_enable_o = tx_enable_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign reg_we_o    = reg_we_q;
    assign reg_re_o    = reg_re_q;
    assign rx_drop_o   = rx_drop_q;

endmodule
